// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, default sizes and width helper for the layer sequencer
package nn_pkg;

  localparam int N_IN    = 16;
  localparam int NEURONS = 4;
  localparam int ACC_W   = 24;
  localparam int BYTES   = ACC_W / 8;

  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    LOAD    = 7'b0000010,
    CLR     = 7'b0000100,
    COMPUTE = 7'b0001000,
    WAIT    = 7'b0010000,
    SEND    = 7'b0100000,
    DONE    = 7'b1000000
  } stateT;

  // Counter/address width, never below one bit so single-entry ranges still synthesize.
  function automatic int addrWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_input_buf.sv
// rtl/nn_input_buf.sv - input byte register file with one write port and a registered read port
module nn_input_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// rtl/nn_layer_sequencer.sv - time-shares one external 8x8 MAC across the neurons of a dense layer
module nn_layer_sequencer #(
  parameter int N_IN    = nn_pkg::N_IN,
  parameter int NEURONS = nn_pkg::NEURONS,
  parameter int ACC_W   = nn_pkg::ACC_W
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       rx_valid,
  input  logic [7:0]                                 rx_byte,
  output logic [nn_pkg::addrWidth(N_IN*NEURONS)-1:0] w_addr,
  input  logic [7:0]                                 w_data,
  output logic                                       mac_clr,
  output logic                                       mac_en,
  output logic [7:0]                                 mac_a,
  output logic [7:0]                                 mac_b,
  input  logic [ACC_W-1:0]                           mac_acc,
  output logic                                       tx_valid,
  input  logic                                       tx_ready,
  output logic [7:0]                                 tx_byte,
  output logic                                       trig_out,
  output logic                                       busy,
  output logic                                       overrun
);

  import nn_pkg::*;

  localparam int NBYTES = ACC_W / 8;
  localparam int KW     = addrWidth(N_IN);
  localparam int NW     = addrWidth(NEURONS);
  localparam int BW     = addrWidth(NBYTES);
  localparam int WA     = addrWidth(N_IN * NEURONS);

  stateT             state, stateNext;
  logic [KW-1:0]     inCnt, k, kSel;
  logic [NW-1:0]     neuron;
  logic [BW-1:0]     byteIdx;
  logic [ACC_W-1:0]  res;
  logic [7:0]        bufRdata;
  logic              bufWe;
  logic [KW-1:0]     bufWaddr;
  logic [NW+KW-1:0]  addrFull;

  assign bufWe    = rx_valid && (state == IDLE || state == LOAD);
  assign bufWaddr = (state == IDLE) ? '0 : inCnt;
  assign addrFull = {neuron, kSel};
  assign busy     = (state != IDLE);

  nn_input_buf #(.DEPTH(N_IN), .AW(KW)) inputBuf (
    .clk   (clk),
    .rst   (rst),
    .we    (bufWe),
    .waddr (bufWaddr),
    .wdata (rx_byte),
    .raddr (kSel),
    .rdata (bufRdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      inCnt   <= '0;
      k       <= '0;
      neuron  <= '0;
      byteIdx <= '0;
      res     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= stateNext;
      if (rx_valid) begin
        if (state == IDLE) begin
          inCnt   <= KW'(1);
          overrun <= 1'b0;
        end else if (state == LOAD) begin
          inCnt <= inCnt + KW'(1);
        end else begin
          overrun <= 1'b1;
        end
      end
      case (state)
        LOAD:    neuron <= '0;
        CLR:     k <= '0;
        COMPUTE: k <= k + KW'(1);
        WAIT: begin
          res     <= mac_acc;
          byteIdx <= BW'(NBYTES - 1);
        end
        SEND: begin
          if (tx_ready) begin
            if (byteIdx != '0)                        byteIdx <= byteIdx - BW'(1);
            else if (neuron != NW'(NEURONS - 1))      neuron  <= neuron + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The read port and ROM both lag one cycle, so addresses run one step ahead of k.
  always_comb begin
    stateNext = state;
    kSel      = '0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    trig_out  = 1'b0;
    tx_valid  = 1'b0;
    case (state)
      IDLE:    if (rx_valid) stateNext = LOAD;
      LOAD:    if (rx_valid && inCnt == KW'(N_IN - 1)) stateNext = CLR;
      CLR: begin
        mac_clr   = 1'b1;
        trig_out  = 1'b1;
        stateNext = COMPUTE;
      end
      COMPUTE: begin
        mac_en   = 1'b1;
        trig_out = 1'b1;
        kSel     = k + KW'(1);
        if (k == KW'(N_IN - 1)) stateNext = WAIT;
      end
      WAIT: begin
        trig_out  = 1'b1;
        stateNext = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && byteIdx == '0)
          stateNext = (neuron == NW'(NEURONS - 1)) ? DONE : CLR;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_addr  = (state == CLR || state == COMPUTE) ? addrFull[WA-1:0] : '0;
    mac_a   = mac_en ? bufRdata : 8'h00;
    mac_b   = mac_en ? w_data : 8'h00;
    tx_byte = tx_valid ? res[{byteIdx, 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb/tb_nn_layer_sequencer.sv - directed bench with ROM and MAC models for nn_layer_sequencer
module tb_nn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [5:0]  w_addr;
  logic [7:0]  w_data;
  logic        mac_clr, mac_en;
  logic [7:0]  mac_a, mac_b;
  logic [23:0] mac_acc;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_byte;
  logic        trig_out, busy, overrun;
  logic        wAll;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [7:0]        inByte;
    logic              wAll;
    int                gap;
    logic [3:0][23:0]  exp;
  } vecT;

  typedef struct {
    int   len;
    int   en;
    int   clr;
    logic first;
  } winT;

  vecT        vecs [4];
  logic [7:0] txq [$];
  winT        winQ [$];
  int         winLen = 0, enCnt = 0, clrCnt = 0;
  logic       firstClr = 1'b0;

  always #5 clk = ~clk;

  nn_layer_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_acc  (mac_acc),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_byte  (tx_byte),
    .trig_out (trig_out),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Weight ROM (w[a]=a+1 or all 0xFF) and registered MAC.
  always @(posedge clk) begin
    w_data <= wAll ? 8'hFF : ({2'b00, w_addr} + 8'd1);
    if (mac_clr)     mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + 24'(mac_a) * 24'(mac_b);
  end

  always @(negedge clk) begin
    if (!rst) begin
      winLen = 0; enCnt = 0; clrCnt = 0;
    end else begin
      if (trig_out) begin
        if (winLen == 0) firstClr = mac_clr;
        winLen++;
        enCnt  += int'(mac_en);
        clrCnt += int'(mac_clr);
      end else if (winLen != 0) begin
        winQ.push_back('{winLen, enCnt, clrCnt, firstClr});
        winLen = 0; enCnt = 0; clrCnt = 0;
      end
      if (tx_valid && tx_ready) txq.push_back(tx_byte);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBytes(input logic [7:0] val, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_byte  = val;
      tick();
      rx_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    check({tag, "_idle"}, busy, 0);
    tick();
  endtask

  task automatic clearQueues();
    txq.delete();
    winQ.delete();
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_w_addr"},   w_addr, 0);
    check({tag, "_mac_clr"},  mac_clr, 0);
    check({tag, "_mac_en"},   mac_en, 0);
    check({tag, "_mac_a"},    mac_a, 0);
    check({tag, "_mac_b"},    mac_b, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_byte"},  tx_byte, 0);
    check({tag, "_trig_out"}, trig_out, 0);
    check({tag, "_overrun"},  overrun, 0);
  endtask

  task automatic checkFrame(input string tag, input logic [3:0][23:0] exp);
    logic [7:0] act;
    check({tag, "_bytes"}, txq.size(), 12);
    for (int n = 0; n < 4; n++) begin
      for (int b = 0; b < 3; b++) begin
        act = (n * 3 + b < txq.size()) ? txq[n * 3 + b] : 8'hxx;
        check($sformatf("%s_n%0d_b%0d", tag, n, b), act, exp[n][8 * (2 - b) +: 8]);
      end
    end
  endtask

  task automatic checkWindows(input string tag);
    check({tag, "_windows"}, winQ.size(), 4);
    for (int i = 0; i < winQ.size(); i++) begin
      check($sformatf("%s_w%0d_len", tag, i),   winQ[i].len, 18);
      check($sformatf("%s_w%0d_en", tag, i),    winQ[i].en, 16);
      check($sformatf("%s_w%0d_clr", tag, i),   winQ[i].clr, 1);
      check($sformatf("%s_w%0d_first", tag, i), winQ[i].first, 1);
    end
  endtask

  initial begin
    int n, clrs, ok;

    vecs[0] = '{8'h01, 1'b0, 3, {24'd904, 24'd648, 24'd392, 24'd136}};
    vecs[1] = '{8'hFF, 1'b1, 0, {24'h0FE010, 24'h0FE010, 24'h0FE010, 24'h0FE010}};
    vecs[2] = '{8'h02, 1'b0, 1, {24'd1808, 24'd1296, 24'd784, 24'd272}};
    vecs[3] = '{8'h00, 1'b1, 0, {24'd0, 24'd0, 24'd0, 24'd0}};

    rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1; wAll = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutputsZero("reset");
    tick();
    rst = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      clearQueues();
      wAll = vecs[v].wAll;
      sendBytes(vecs[v].inByte, 16, vecs[v].gap);
      waitIdle($sformatf("vec%0d", v));
      checkFrame($sformatf("vec%0d", v), vecs[v].exp);
      checkWindows($sformatf("vec%0d", v));
      check($sformatf("vec%0d_overrun", v), overrun, 0);
    end

    // Backpressure on the first result byte.
    clearQueues();
    wAll = 1'b0;
    tx_ready = 1'b0;
    sendBytes(8'h01, 16, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 200);
    check("bp_valid_seen", tx_valid, 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid === 1'b1 && tx_byte === 8'h00) ok++;
      @(negedge clk);
    end
    check("bp_hold", ok, 20);
    tick();
    tx_ready = 1'b1;
    waitIdle("bp");
    checkFrame("bp", vecs[0].exp);

    // Stray byte while computing.
    clearQueues();
    sendBytes(8'h01, 16, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mac_en && n < 50);
    check("ovr_in_compute", mac_en, 1);
    tick();
    rx_valid = 1'b1;
    rx_byte  = 8'h55;
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    check("ovr_set", overrun, 1);
    waitIdle("ovr");
    checkFrame("ovr", vecs[0].exp);
    check("ovr_sticky", overrun, 1);
    clearQueues();
    wAll = 1'b1;
    sendBytes(8'hFF, 1, 0);
    @(negedge clk);
    check("ovr_cleared", overrun, 0);
    tick();
    sendBytes(8'hFF, 15, 2);
    waitIdle("ovr_next");
    checkFrame("ovr_next", vecs[1].exp);

    // Reset in the middle of neuron 2.
    clearQueues();
    wAll = 1'b0;
    sendBytes(8'h01, 16, 0);
    clrs = 0;
    n = 0;
    while (clrs < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (mac_clr) clrs++;
    end
    check("rst_reach_n2", clrs, 3);
    repeat (5) @(negedge clk);
    check("rst_in_compute", mac_en, 1);
    tick();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutputsZero("rst_mid");
    tick();
    rst = 1'b1;
    clearQueues();
    sendBytes(8'h01, 16, 0);
    waitIdle("rst_fresh");
    checkFrame("rst_fresh", vecs[0].exp);
    checkWindows("rst_fresh");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Controller that time-shares one external 8x8 multiply-accumulate datapath across NEURONS neurons of a fully connected layer.
- Collects N_IN input bytes from the UART RX byte stream into a local buffer.
- For each neuron in turn, streams buffer bytes and weight-ROM addresses into the MAC, captures the accumulator, and sends the result MSB-first as bytes over the UART TX handshake.
- Drives a scope trigger that is high exactly while the MAC is computing, framing the power-trace capture window.

Parameters:
- N_IN, 16, inputs per neuron (power of two, 2..64).
- NEURONS, 4, neurons in the layer (1..16).
- ACC_W, 24, accumulator/result width (multiple of 8).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new byte.
- rx_byte  in  8  received input byte.
- w_addr  out  clog2(N_IN*NEURONS)  weight ROM address; ROM data is valid 1 cycle later.
- w_data  in  8  weight ROM read data.
- mac_clr  out  1  one-cycle pulse that zeroes the external accumulator.
- mac_en  out  1  accumulate strobe: acc <= acc + mac_a*mac_b.
- mac_a  out  8  input operand (registered buffer byte).
- mac_b  out  8  weight operand (w_data, passed through).
- mac_acc  in  ACC_W  external accumulator value (registered in the MAC).
- tx_valid  out  1  tx_byte is valid.
- tx_ready  in  1  UART TX accepts the byte.
- tx_byte  out  8  result byte.
- trig_out  out  1  scope trigger.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky flag: rx_valid arrived outside LOAD; cleared on the next entry to LOAD.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. Buffer contents are don't-care.
- Reset wins over every other event, including mid-compute and mid-send. Any in-flight result is dropped and the bench must not expect a partial frame.
- States: IDLE, LOAD, CLR, COMPUTE, WAIT, SEND, DONE.
- IDLE: on rx_valid, store the byte at buf[0], set in_cnt=1, clear overrun, go to LOAD.
- LOAD: each rx_valid stores buf[in_cnt] and increments in_cnt.
  - When the N_IN-th byte is stored, go to CLR with neuron=0.
  - An rx_valid in the same cycle as the exit edge is the last accepted byte.
- CLR (1 cycle): mac_clr=1, k=0; w_addr = neuron*N_IN + 0 is issued in this cycle. Go to COMPUTE.
- COMPUTE (N_IN cycles, k=0..N_IN-1):
  - mac_en=1, mac_a=buf[k] registered (aligned with the ROM latency), mac_b=w_data.
  - w_addr = neuron*N_IN + k + 1 is pre-issued; the value is don't-care on the last cycle.
  - Exit to WAIT after k=N_IN-1.
- WAIT (1 cycle): mac_en=0; latch res <= mac_acc; byte_idx=ACC_W/8-1. Go to SEND.
- SEND:
  - tx_byte = res[8*byte_idx +: 8]; tx_valid=1.
  - A byte transfers on tx_valid && tx_ready.
  - tx_byte stays stable until accepted; tx_valid never drops without a transfer.
  - After byte 0 transfers: if neuron==NEURONS-1 go to DONE, else neuron++ and go to CLR.
- DONE (1 cycle): go to IDLE.
- trig_out=1 in CLR, COMPUTE and WAIT only, so it goes low while sending.
- Compute latency per neuron: N_IN+2 cycles from CLR to res latched.
- overrun: rx_valid in any state other than IDLE/LOAD sets it; the byte is discarded.
- Width: the product is 16 bit; the external MAC wraps modulo 2^ACC_W, and the controller does no saturation.

Decomposition:
- Package nn_pkg holds:
  - the state enum (one-hot encoding);
  - localparams for N_IN, NEURONS, ACC_W and BYTES=ACC_W/8;
  - the address-width function.
- One natural sub-module, nn_input_buf: N_IN x 8 register file with a write port (we, waddr, wdata) and a registered read port (raddr -> rdata).

Test Plan:
- Weight ROM model w[a]=a+1; send 16 bytes of 0x01 with 3 idle cycles between them.
  - Required: TX bytes 00 00 88, 00 01 88, 00 02 88, 00 03 88 (sums 136, 392, 648, 904).
  - Then busy falls and the block returns to IDLE.
- Inputs all 0xFF, weights all 0xFF.
  - Required: each neuron outputs 0x0FE010 (16*65025), i.e. bytes 0F E0 10.
- tx_ready held low 20 cycles on the first byte.
  - Required: tx_valid stays 1 and tx_byte stays 0x00 throughout; no byte is lost or duplicated.
- Check trig_out framing per neuron.
  - Required: high for exactly N_IN+2=18 cycles per neuron.
  - mac_en is high for exactly 16 cycles inside that window.
  - mac_clr pulses once, in the first cycle of the window.
- rx_valid pulse during COMPUTE.
  - Required: overrun=1 and results are unchanged.
  - overrun clears when the next frame's first byte arrives.
- rst low during neuron 2 COMPUTE.
  - Required: the next cycle shows all outputs 0 and busy=0.
  - A fresh 16-byte frame afterwards produces correct results from neuron 0.
